// File: rtl/jtag_tap_ctrl_if.sv
// jtag_tap_ctrl_if: JTAG pin and core-side signal bundle for the TAP controller.
interface jtag_tap_ctrl_if #(
  parameter int IR_W   = 4,
  parameter int USER_W = 8
);
  logic              TMS;
  logic              TDI;
  logic              TDO;
  logic              TDO_EN;
  logic [3:0]        state_obs;
  logic [IR_W-1:0]   ir_out;
  logic              capture_dr;
  logic              shift_dr;
  logic              update_dr;
  logic [USER_W-1:0] user_dr_in;
  logic [USER_W-1:0] user_dr_out;
  modport master (
    output TMS, TDI, user_dr_in,
    input  TDO, TDO_EN, state_obs, ir_out, capture_dr, shift_dr, update_dr, user_dr_out
  );
  modport slave (
    input  TMS, TDI, user_dr_in,
    output TDO, TDO_EN, state_obs, ir_out, capture_dr, shift_dr, update_dr, user_dr_out
  );
endinterface

// File: rtl/jtag_tap_ctrl.sv
// jtag_tap_ctrl: IEEE 1149.1 TAP state machine with IR, BYPASS/IDCODE/USER DRs and TDO path.
module jtag_tap_ctrl #(
   parameter int              IR_W       = 4,
   parameter int              USER_W     = 8,
   parameter logic [31:0]     IDCODE_VAL = 32'h1234_5A6B,
   parameter logic [IR_W-1:0] IR_IDCODE  = 4'b0001,
   parameter logic [IR_W-1:0] IR_USER    = 4'b0010,
   parameter logic [IR_W-1:0] IR_CAPTURE = 4'b0001
) (
   input logic            TCK,
   input logic            TRST_N,
   jtag_tap_ctrl_if.slave bus
);
   typedef enum logic [3:0] {
      TLR, RTI, SEL_DR, CAP_DR, SH_DR, EX1_DR, PAU_DR, EX2_DR,
      UPD_DR, SEL_IR, CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR
   } state_t;

   state_t            state, nxt;
   logic [IR_W-1:0]   ir_sr, ir;
   logic [31:0]       id_sr;
   logic [USER_W-1:0] user_sr, user_q;
   logic              byp_sr, tdo, tdo_en;
   logic              sel_id, sel_user, dr_lsb;

   assign sel_id   = ir == IR_IDCODE;
   assign sel_user = ir == IR_USER && !sel_id;
   assign dr_lsb   = sel_id ? id_sr[0] : sel_user ? user_sr[0] : byp_sr;

   always_comb begin
      nxt = TLR;
      case (state)
         TLR:     nxt = bus.TMS ? TLR    : RTI;
         RTI:     nxt = bus.TMS ? SEL_DR : RTI;
         SEL_DR:  nxt = bus.TMS ? SEL_IR : CAP_DR;
         CAP_DR:  nxt = bus.TMS ? EX1_DR : SH_DR;
         SH_DR:   nxt = bus.TMS ? EX1_DR : SH_DR;
         EX1_DR:  nxt = bus.TMS ? UPD_DR : PAU_DR;
         PAU_DR:  nxt = bus.TMS ? EX2_DR : PAU_DR;
         EX2_DR:  nxt = bus.TMS ? UPD_DR : SH_DR;
         UPD_DR:  nxt = bus.TMS ? SEL_DR : RTI;
         SEL_IR:  nxt = bus.TMS ? TLR    : CAP_IR;
         CAP_IR:  nxt = bus.TMS ? EX1_IR : SH_IR;
         SH_IR:   nxt = bus.TMS ? EX1_IR : SH_IR;
         EX1_IR:  nxt = bus.TMS ? UPD_IR : PAU_IR;
         PAU_IR:  nxt = bus.TMS ? EX2_IR : PAU_IR;
         EX2_IR:  nxt = bus.TMS ? UPD_IR : SH_IR;
         UPD_IR:  nxt = bus.TMS ? SEL_DR : RTI;
         default: nxt = TLR;
      endcase
   end

   // Register actions are keyed on the state being left at this rising edge.
   always_ff @(posedge TCK or negedge TRST_N)
      if (!TRST_N) begin
         state   <= TLR;
         ir_sr   <= '0;
         ir      <= IR_IDCODE;
         id_sr   <= '0;
         user_sr <= '0;
         byp_sr  <= 1'b0;
         user_q  <= '0;
      end else begin
         state <= nxt;
         case (state)
            TLR: begin
               ir     <= IR_IDCODE;
               user_q <= '0;
            end
            CAP_IR: ir_sr <= IR_CAPTURE;
            SH_IR:  ir_sr <= IR_W'({bus.TDI, ir_sr} >> 1);
            UPD_IR: ir    <= ir_sr;
            CAP_DR: begin
               if (sel_id) id_sr <= IDCODE_VAL;
               if (sel_user) user_sr <= bus.user_dr_in;
               if (!sel_id && !sel_user) byp_sr <= 1'b0;
            end
            SH_DR: begin
               if (sel_id) id_sr <= 32'({bus.TDI, id_sr} >> 1);
               if (sel_user) user_sr <= USER_W'({bus.TDI, user_sr} >> 1);
               if (!sel_id && !sel_user) byp_sr <= bus.TDI;
            end
            UPD_DR: if (sel_user) user_q <= user_sr;
            default: ;
         endcase
      end

   always_ff @(negedge TCK or negedge TRST_N)
      if (!TRST_N) begin
         tdo    <= 1'b0;
         tdo_en <= 1'b0;
      end else begin
         tdo    <= state == SH_IR ? ir_sr[0] : state == SH_DR ? dr_lsb : 1'b0;
         tdo_en <= state == SH_IR || state == SH_DR;
      end

   assign bus.TDO         = tdo;
   assign bus.TDO_EN      = tdo_en;
   assign bus.state_obs   = state;
   assign bus.ir_out      = ir;
   assign bus.user_dr_out = user_q;
   assign bus.capture_dr  = state == CAP_DR && ir == IR_USER;
   assign bus.shift_dr    = state == SH_DR && ir == IR_USER;
   assign bus.update_dr   = state == UPD_DR && ir == IR_USER;
endmodule

// File: tb/tb_jtag_tap_ctrl.sv
// tb_jtag_tap_ctrl: randomized scoreboard bench for jtag_tap_ctrl against a queue-based TAP model.
module tb_jtag_tap_ctrl;
   localparam int          IR_W    = 4;
   localparam int          USER_W  = 8;
   localparam logic [31:0] IDV     = 32'h1234_5A6B;
   localparam logic [3:0]  OP_ID   = 4'b0001;
   localparam logic [3:0]  OP_USER = 4'b0010;
   localparam logic [3:0]  OP_CAP  = 4'b0001;
   localparam int          VW      = 4 + 2 + IR_W + 3 + USER_W;

   logic TCK = 1'b0;
   logic TRST_N;
   jtag_tap_ctrl_if #(.IR_W(IR_W), .USER_W(USER_W)) bus();
   jtag_tap_ctrl #(.IR_W(IR_W), .USER_W(USER_W), .IDCODE_VAL(IDV),
                   .IR_IDCODE(OP_ID), .IR_USER(OP_USER), .IR_CAPTURE(OP_CAP))
      dut (.TCK(TCK), .TRST_N(TRST_N), .bus(bus.slave));

   always #5 TCK = ~TCK;

   int n_chk = 0, n_fail = 0;
   logic [VW-1:0] sb[$];
   int nx0[16] = '{1, 1, 3, 4, 4, 6, 6, 4, 1, 10, 11, 11, 13, 13, 11, 1};
   int nx1[16] = '{0, 2, 9, 5, 5, 8, 7, 8, 2, 0, 12, 12, 15, 14, 15, 2};
   int pr_len[16]  = '{3, 0, 1, 2, 3, 3, 4, 5, 4, 2, 3, 4, 4, 5, 6, 5};
   int pr_bits[16] = '{7, 0, 1, 1, 1, 5, 5, 21, 13, 3, 3, 3, 11, 11, 43, 27};

   // Model: the active shift path is a bit queue, front = bit presented on TDO.
   int                st;
   logic [IR_W-1:0]   m_ir;
   logic [USER_W-1:0] m_udo;
   bit                ir_q[$], dr_q[$];

   logic [VW-1:0] obs;
   assign obs = {bus.state_obs, bus.TDO, bus.TDO_EN, bus.ir_out,
                 bus.capture_dr, bus.shift_dr, bus.update_dr, bus.user_dr_out};

   function automatic logic [VW-1:0] expv();
      logic u, t;
      u = m_ir == OP_USER;
      t = st == 11 ? ir_q[0] : st == 4 ? dr_q[0] : 1'b0;
      return {4'(st), t, st == 4 || st == 11, m_ir, st == 3 && u, st == 4 && u, st == 8 && u, m_udo};
   endfunction

   function automatic logic [USER_W-1:0] rui();
      return USER_W'($urandom);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s @%0t: actual=%h required=%h", nm, $time, act, req);
      end
   endtask

   task automatic model_reset();
      st = 0;
      m_ir = OP_ID;
      m_udo = '0;
      ir_q.delete();
      repeat (IR_W) ir_q.push_back(1'b0);
      dr_q.delete();
      dr_q.push_back(1'b0);
   endtask

   task automatic step(input bit tms, input bit tdi, input logic [USER_W-1:0] ui);
      int os;
      bus.TMS = tms;
      bus.TDI = tdi;
      bus.user_dr_in = ui;
      @(posedge TCK);
      os = st;
      st = tms ? nx1[os] : nx0[os];
      case (os)
         0: begin
            m_ir = OP_ID;
            m_udo = '0;
         end
         3: begin
            dr_q.delete();
            if (m_ir == OP_ID) for (int i = 0; i < 32; i++) dr_q.push_back(IDV[i]);
            else if (m_ir == OP_USER) for (int i = 0; i < USER_W; i++) dr_q.push_back(ui[i]);
            else dr_q.push_back(1'b0);
         end
         4: begin
            dr_q.push_back(tdi);
            void'(dr_q.pop_front());
         end
         8: if (m_ir == OP_USER) for (int i = 0; i < USER_W; i++) m_udo[i] = dr_q[i];
         10: begin
            ir_q.delete();
            for (int i = 0; i < IR_W; i++) ir_q.push_back(OP_CAP[i]);
         end
         11: begin
            ir_q.push_back(tdi);
            void'(ir_q.pop_front());
         end
         15: for (int i = 0; i < IR_W; i++) m_ir[i] = ir_q[i];
         default: ;
      endcase
      sb.push_back(expv());
      #1;
   endtask

   task automatic ones(input int n);
      repeat (n) step(1'b1, 1'($urandom), rui());
   endtask

   task automatic load_ir(input logic [IR_W-1:0] op);
      step(1, 0, rui());
      step(1, 0, rui());
      step(0, 0, rui());
      step(0, 0, rui());
      for (int i = 0; i < IR_W; i++) step(i == IR_W - 1, op[i], rui());
      step(1, 0, rui());
      step(0, 0, rui());
   endtask

   task automatic scan_dr(input logic [63:0] d, input int n, input logic [USER_W-1:0] ui);
      step(1, 0, ui);
      step(0, 0, ui);
      step(0, 0, ui);
      for (int i = 0; i < n; i++) step(i == n - 1, d[i], ui);
      step(1, 0, ui);
      step(0, 0, ui);
   endtask

   initial begin
      forever begin
         @(negedge TCK);
         #1;
         if (sb.size() != 0) chk("cycle", 32'(obs), 32'(sb.pop_front()));
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL timeout: actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      logic [IR_W-1:0] op;
      int b;
      TRST_N = 1'b1;
      bus.TMS = 1'b1;
      bus.TDI = 1'b0;
      bus.user_dr_in = '0;
      model_reset();
      #1 TRST_N = 1'b0;
      #2 chk("reset", 32'(obs), 32'(expv()));
      #5 TRST_N = 1'b1;
      step(0, 0, rui());
      scan_dr(64'd0, 32, rui());
      load_ir(4'hF);
      chk("ir_bypass", 32'(bus.ir_out), 32'hF);
      scan_dr(64'b01101, 5, rui());
      load_ir(OP_USER);
      scan_dr(64'h3C, 8, 8'hA5);
      chk("user_dr_out", 32'(bus.user_dr_out), 32'h3C);
      step(1, 0, rui());
      step(0, 0, rui());
      step(0, 0, rui());
      repeat (4) step(0, 1'($urandom), rui());
      @(negedge TCK);
      #2 chk("drain", sb.size(), 0);
      TRST_N = 1'b0;
      model_reset();
      #1 chk("trst_mid", 32'(obs), 32'(expv()));
      #1 TRST_N = 1'b1;
      step(0, 0, rui());
      for (int s = 0; s < 16; s++) begin
         step(0, 0, rui());
         case ($urandom_range(0, 3))
            0: op = OP_ID;
            1: op = 4'hF;
            2: op = IR_W'($urandom);
            default: op = OP_USER;
         endcase
         load_ir(op);
         scan_dr({$urandom, $urandom}, $urandom_range(1, 40), rui());
         b = pr_bits[s];
         for (int i = 0; i < pr_len[s]; i++) step(b[i], 1'($urandom), rui());
         chk("tour_at", 32'(bus.state_obs), s);
         ones(5);
         chk("tour_tlr", 32'(bus.state_obs), 0);
      end
      repeat (400) step($urandom_range(0, 2) == 0, 1'($urandom), rui());
      ones(5);
      repeat (2) @(negedge TCK);
      #2 chk("drain_end", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
